// File: rtl/game_pkg.sv
// Shared definitions for the memory-sequence game: state encoding, sequence
// geometry, LFSR taps and the digit-select helper.
package game_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 5;
  localparam int SEQ_W      = DIGIT_W * NUM_DIGITS;
  localparam int STATE_W    = 4;
  localparam int LVL_W      = 3;
  localparam int IDX_W      = 3;

  // Fibonacci taps for x^20 + x^17 + 1 (bit positions in a left-shifting register)
  localparam int LFSR_TAP_HI = 19;
  localparam int LFSR_TAP_LO = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    SHOW      = 4'd2,
    WAIT_SHOW = 4'd3,
    INPUT     = 4'd4,
    LEVEL_UP  = 4'd5,
    WIN       = 4'd6,
    LOSE      = 4'd7
  } state_t;

  // Digit 0 is the most significant nibble, i.e. the first one played back
  function automatic logic [DIGIT_W-1:0] seq_digit(input logic [SEQ_W-1:0] s,
                                                   input logic [IDX_W-1:0] k);
    logic [DIGIT_W-1:0] d;
    d = '0;
    case (k)
      3'd0:    d = s[19:16];
      3'd1:    d = s[15:12];
      3'd2:    d = s[11:8];
      3'd3:    d = s[7:4];
      3'd4:    d = s[3:0];
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the round controller and the rest of the game
// (player keypad, playback unit, status LEDs).
interface game_round_ctrl_if;
  import game_pkg::*;

  logic                 start;
  logic                 use_fixed;
  logic [SEQ_W-1:0]     fixed_seq;
  logic                 key_valid;
  logic [DIGIT_W-1:0]   key_digit;
  logic                 displayDone;
  logic                 display;
  logic [LVL_W-1:0]     curLvl;
  logic [SEQ_W-1:0]     seq;
  logic                 win;
  logic                 lose;
  logic [STATE_W-1:0]   state_o;

  // Controller side: consumes player/playback inputs, drives game status
  modport master (
    input  start, use_fixed, fixed_seq, key_valid, key_digit, displayDone,
    output display, curLvl, seq, win, lose, state_o
  );

  // Environment side: keypad, playback unit and observers
  modport slave (
    output start, use_fixed, fixed_seq, key_valid, key_digit, displayDone,
    input  display, curLvl, seq, win, lose, state_o
  );

endinterface

// File: rtl/game_round_ctrl_seq_lfsr.sv
// Free-running 20-bit Fibonacci LFSR that supplies fresh game sequences.
module seq_lfsr
  import game_pkg::*;
#(
  parameter logic [SEQ_W-1:0] SEED = 20'hACE1F
) (
  input  logic             clk,
  input  logic             rst,
  output logic [SEQ_W-1:0] value
);

  // Shift left every cycle; a non-zero seed keeps the register out of the lock-up state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else begin
      value <= {value[SEQ_W-2:0], value[LFSR_TAP_HI] ^ value[LFSR_TAP_LO]};
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: loads a sequence, triggers playback, checks the player's
// entries digit by digit and decides level-up, win or loss.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int               MAX_LVL       = 5,
  parameter int               INPUT_TIMEOUT = 250000000,
  parameter logic [SEQ_W-1:0] LFSR_SEED     = 20'hACE1F
) (
  input  logic               clk,
  input  logic               rst,
  game_round_ctrl_if.master  bus
);

  localparam int                CNT_W    = (INPUT_TIMEOUT > 1) ? $clog2(INPUT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INPUT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(MAX_LVL);

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [CNT_W-1:0]   tmo_cnt, cnt_next;
  logic [LVL_W-1:0]   cur_lvl, lvl_next;
  logic [SEQ_W-1:0]   seq_r, seq_next;
  logic               display_r, win_r, lose_r;
  logic [SEQ_W-1:0]   lfsr_value;
  logic [DIGIT_W-1:0] cur_digit;
  logic [IDX_W-1:0]   last_idx;

  seq_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign cur_digit = seq_digit(seq_r, idx);
  assign last_idx  = IDX_W'(cur_lvl - 3'd1);

  // State, datapath and registered status flags; flags follow the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      tmo_cnt   <= '0;
      cur_lvl   <= '0;
      seq_r     <= '0;
      display_r <= 1'b0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= idx_next;
      tmo_cnt   <= cnt_next;
      cur_lvl   <= lvl_next;
      seq_r     <= seq_next;
      display_r <= (next_state == SHOW);
      win_r     <= (next_state == WIN);
      lose_r    <= (next_state == LOSE);
    end
  end

  // Next-state and datapath updates; a key in the terminal timeout cycle takes priority
  always_comb begin
    next_state = state;
    idx_next   = idx;
    cnt_next   = tmo_cnt;
    lvl_next   = cur_lvl;
    seq_next   = seq_r;
    case (state)
      IDLE: begin
        if (bus.start) next_state = LOAD;
      end
      LOAD: begin
        seq_next   = bus.use_fixed ? bus.fixed_seq : lfsr_value;
        lvl_next   = 3'd1;
        next_state = SHOW;
      end
      SHOW: begin
        next_state = WAIT_SHOW;
      end
      WAIT_SHOW: begin
        if (bus.displayDone) begin
          next_state = INPUT;
          idx_next   = '0;
          cnt_next   = '0;
        end
      end
      INPUT: begin
        if (bus.key_valid) begin
          cnt_next = '0;
          if (bus.key_digit != cur_digit) begin
            next_state = LOSE;
          end else if (idx == last_idx) begin
            next_state = LEVEL_UP;
          end else begin
            idx_next = idx + 3'd1;
          end
        end else begin
          if (tmo_cnt != CNT_MAX) cnt_next = tmo_cnt + 1'b1;
          if (tmo_cnt == CNT_LAST) next_state = LOSE;
        end
      end
      LEVEL_UP: begin
        if (cur_lvl == LVL_MAX) begin
          next_state = WIN;
        end else begin
          lvl_next   = cur_lvl + 3'd1;
          next_state = SHOW;
        end
      end
      WIN, LOSE: begin
        if (bus.start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.display = display_r;
  assign bus.curLvl  = cur_lvl;
  assign bus.seq     = seq_r;
  assign bus.win     = win_r;
  assign bus.lose    = lose_r;
  assign bus.state_o = state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: full win, wrong-digit loss, timeout,
// LFSR-sourced sequence and asynchronous reset mid-game.
module tb_game_round_ctrl;

  localparam logic [19:0] FIXED = 20'h79BCC;
  localparam logic [19:0] SEED  = 20'hACE1F;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [19:0] model_lfsr;
  logic [19:0] lfsr_exp;
  logic [3:0]  digs [5];

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .MAX_LVL       (5),
    .INPUT_TIMEOUT (100),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference x^20+x^17+1 Fibonacci LFSR running alongside the design
  always @(posedge clk or negedge rst) begin
    if (!rst) model_lfsr <= SEED;
    else      model_lfsr <= {model_lfsr[18:0], model_lfsr[19] ^ model_lfsr[16]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_game(input logic fixed, input logic [19:0] s);
    bus.start     = 1'b1;
    bus.use_fixed = fixed;
    bus.fixed_seq = s;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic show_done();
    bus.displayDone = 1'b1;
    tick();
    bus.displayDone = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // From WAIT_SHOW at level n with the fixed sequence: clear it and return to WAIT_SHOW
  task automatic clear_level(input int n);
    show_done();
    for (int k = 0; k < n; k++) key(digs[k]);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    digs[0] = 4'h7; digs[1] = 4'h9; digs[2] = 4'hB; digs[3] = 4'hC; digs[4] = 4'hC;
    bus.start = 0; bus.use_fixed = 0; bus.fixed_seq = '0;
    bus.key_valid = 0; bus.key_digit = '0; bus.displayDone = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    tick(); tick();

    $display("[TB] reset values");
    check_output("rst_display", 32'(bus.display), 32'd0);
    check_output("rst_curLvl",  32'(bus.curLvl),  32'd0);
    check_output("rst_seq",     32'(bus.seq),     32'd0);
    check_output("rst_win",     32'(bus.win),     32'd0);
    check_output("rst_lose",    32'(bus.lose),    32'd0);
    check_output("rst_state",   32'(bus.state_o), 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] fixed sequence start and playback pulse");
    start_game(1'b1, FIXED);
    check_output("t1_load_state",   32'(bus.state_o), 32'd1);
    check_output("t1_load_display", 32'(bus.display), 32'd0);
    tick();
    check_output("t1_show_display", 32'(bus.display), 32'd1);
    check_output("t1_seq",          32'(bus.seq),     32'h79BCC);
    check_output("t1_curLvl",       32'(bus.curLvl),  32'd1);
    bus.displayDone = 1'b1;
    tick();
    bus.displayDone = 1'b0;
    check_output("t1_display_drop", 32'(bus.display), 32'd0);
    check_output("t1_done_in_show", 32'(bus.state_o), 32'd3);

    $display("[TB] play through all levels to a win");
    for (int lvl = 1; lvl <= 5; lvl++) begin
      show_done();
      check_output("t2_input", 32'(bus.state_o), 32'd4);
      for (int k = 0; k < lvl; k++) begin
        key(digs[k]);
        if (k < lvl - 1) check_output("t2_mid_key", 32'(bus.state_o), 32'd4);
      end
      check_output("t2_level_up", 32'(bus.state_o), 32'd5);
      tick();
      if (lvl < 5) begin
        check_output("t2_show_display", 32'(bus.display), 32'd1);
        check_output("t2_curLvl",       32'(bus.curLvl),  32'(lvl + 1));
        tick();
        check_output("t2_wait_show",    32'(bus.state_o), 32'd3);
      end else begin
        check_output("t2_win_state",  32'(bus.state_o), 32'd6);
        check_output("t2_win_flag",   32'(bus.win),     32'd1);
        check_output("t2_win_curLvl", 32'(bus.curLvl),  32'd5);
      end
    end

    $display("[TB] wrong digit at level 3");
    start_game(1'b1, FIXED);
    check_output("t3_win_cleared", 32'(bus.win),    32'd0);
    tick(); tick();
    clear_level(1);
    clear_level(2);
    check_output("t3_curLvl3", 32'(bus.curLvl), 32'd3);
    show_done();
    key(4'h7);
    key(4'h9);
    check_output("t3_before_bad", 32'(bus.lose), 32'd0);
    key(4'hA);
    check_output("t3_lose_state",  32'(bus.state_o), 32'd7);
    check_output("t3_lose_flag",   32'(bus.lose),    32'd1);
    check_output("t3_lose_curLvl", 32'(bus.curLvl),  32'd3);
    key(4'h7);
    key(4'hB);
    check_output("t3_keys_ignored", 32'(bus.state_o), 32'd7);
    check_output("t3_lvl_held",     32'(bus.curLvl),  32'd3);

    $display("[TB] input timeout");
    start_game(1'b1, FIXED);
    tick(); tick();
    show_done();
    repeat (99) tick();
    check_output("t4_edge99_state", 32'(bus.state_o), 32'd4);
    check_output("t4_edge99_lose",  32'(bus.lose),    32'd0);
    tick();
    check_output("t4_timeout_state", 32'(bus.state_o), 32'd7);
    check_output("t4_timeout_lose",  32'(bus.lose),    32'd1);

    start_game(1'b1, FIXED);
    tick(); tick();
    clear_level(1);
    show_done();
    repeat (99) tick();
    key(4'h7);
    check_output("t4_key_saves",    32'(bus.state_o), 32'd4);
    check_output("t4_key_saves_ls", 32'(bus.lose),    32'd0);
    repeat (99) tick();
    check_output("t4_restart_99", 32'(bus.state_o), 32'd4);
    tick();
    check_output("t4_restart_100", 32'(bus.state_o), 32'd7);

    $display("[TB] LFSR sourced sequence");
    bus.use_fixed = 1'b0;
    bus.start     = 1'b1;
    tick();
    lfsr_exp  = model_lfsr;
    bus.start = 1'b0;
    tick();
    check_output("t5_seq",     32'(bus.seq),     32'(lfsr_exp));
    check_output("t5_curLvl",  32'(bus.curLvl),  32'd1);
    check_output("t5_lose",    32'(bus.lose),    32'd0);
    check_output("t5_display", 32'(bus.display), 32'd1);
    tick();
    show_done();
    key(lfsr_exp[19:16]);
    check_output("t5_digit_ok", 32'(bus.state_o), 32'd5);

    $display("[TB] asynchronous reset mid-game");
    tick(); tick();
    show_done();
    key(lfsr_exp[19:16]);
    key(lfsr_exp[15:12]);
    tick(); tick();
    check_output("t6_lvl3", 32'(bus.curLvl), 32'd3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_output("t6_start_ignored", 32'(bus.state_o), 32'd3);
    #3 rst = 1'b0;
    #1;
    check_output("t6_curLvl",  32'(bus.curLvl),  32'd0);
    check_output("t6_seq",     32'(bus.seq),     32'd0);
    check_output("t6_display", 32'(bus.display), 32'd0);
    check_output("t6_state",   32'(bus.state_o), 32'd0);
    tick();
    rst = 1'b1;
    bus.displayDone = 1'b1;
    repeat (3) tick();
    bus.displayDone = 1'b0;
    check_output("t6_done_ignored", 32'(bus.state_o), 32'd0);
    check_output("t6_idle_lvl",     32'(bus.curLvl),  32'd0);

    start_game(1'b1, FIXED);
    tick();
    check_output("t6_pulse_up", 32'(bus.display), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("t6_pulse_dropped", 32'(bus.display), 32'd0);
    check_output("t6_pulse_state",   32'(bus.state_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
